// File: rtl/ldpc_decode_ctrl_p_if.sv
// Handshake bundle between the LDPC frame controller and the buffer / NMS core / output shifter.
interface ldpc_decode_ctrl_p_if #(
  parameter int ITER_W = 4,
  parameter int AW_IN  = 5,
  parameter int AW_OUT = 4
);
  logic              ready;
  logic              en_din;
  logic [ITER_W-1:0] max_iter_cfg;
  logic              iter_done;
  logic              syndrome_ok;
  logic              out_ready;
  logic              abort;
  logic              load;
  logic [AW_IN-1:0]  load_addr;
  logic              start_iter;
  logic              first_iter;
  logic              load_vout;
  logic              en_out;
  logic              shift_out;
  logic [AW_OUT-1:0] out_addr;
  logic              rst_flag;
  logic              busy;
  logic              frame_done;
  logic              decode_ok;
  logic [ITER_W-1:0] iter_count;

  modport slave (
    input  ready, en_din, max_iter_cfg, iter_done, syndrome_ok, out_ready, abort,
    output load, load_addr, start_iter, first_iter, load_vout, en_out, shift_out,
           out_addr, rst_flag, busy, frame_done, decode_ok, iter_count
  );

  modport master (
    output ready, en_din, max_iter_cfg, iter_done, syndrome_ok, out_ready, abort,
    input  load, load_addr, start_iter, first_iter, load_vout, en_out, shift_out,
           out_addr, rst_flag, busy, frame_done, decode_ok, iter_count
  );
endinterface

// File: rtl/ldpc_decode_ctrl_p.sv
// Frame sequencer for the QC-LDPC NMS decoder: load, iterate with early exit, unload.
// state | meaning
// IDLE  | waiting for ready, limit latched on exit
// LOAD  | counting accepted input words
// START | one-cycle start_iter pulse
// ITER  | waiting for iter_done from the NMS core
// FLUSH | capture hard decisions into the output shifter
// OUT   | streaming output words under backpressure
// DONE  | frame_done pulse with flag clear
module ldpc_decode_ctrl_p #(
  parameter int LOAD_WORDS = 24,
  parameter int OUT_WORDS  = 12,
  parameter int MAX_ITER   = 15,
  parameter int ITER_W     = 4,
  parameter int AW_IN      = 5,
  parameter int AW_OUT     = 4
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  ldpc_decode_ctrl_p_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_ITER  = 3'd3,
    S_FLUSH = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [ITER_W-1:0] LP_MAX_ITER  = ITER_W'(MAX_ITER);
  localparam logic [AW_IN-1:0]  LP_LOAD_LAST = AW_IN'(LOAD_WORDS - 1);
  localparam logic [AW_OUT-1:0] LP_OUT_LAST  = AW_OUT'(OUT_WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [AW_IN-1:0]  r_load_cnt;
  logic [AW_OUT-1:0] r_out_cnt;
  logic [ITER_W-1:0] r_iter_cnt;
  logic [ITER_W-1:0] r_limit;
  logic              r_decode_ok;
  logic [ITER_W-1:0] w_cfg_limit;
  logic [ITER_W-1:0] w_iter_inc;
  logic              w_abort;

  assign w_cfg_limit = (bus.max_iter_cfg == '0 || bus.max_iter_cfg > LP_MAX_ITER)
                       ? LP_MAX_ITER : bus.max_iter_cfg;
  assign w_iter_inc  = r_iter_cnt + ITER_W'(1);
  assign w_abort     = bus.abort && (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.ready) w_next = S_LOAD;
        S_LOAD:  if (bus.en_din && r_load_cnt == LP_LOAD_LAST) w_next = S_START;
        S_START: w_next = S_ITER;
        S_ITER: begin
          if (bus.iter_done) begin
            if (bus.syndrome_ok || w_iter_inc == r_limit) w_next = S_FLUSH;
            else                                          w_next = S_START;
          end
        end
        S_FLUSH: w_next = S_OUT;
        S_OUT:   if (bus.out_ready && r_out_cnt == LP_OUT_LAST) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.load       = 1'b0;
    bus.load_addr  = '0;
    bus.start_iter = 1'b0;
    bus.first_iter = 1'b0;
    bus.load_vout  = 1'b0;
    bus.en_out     = 1'b0;
    bus.shift_out  = 1'b0;
    bus.out_addr   = '0;
    bus.rst_flag   = 1'b1;
    bus.frame_done = 1'b0;
    bus.busy       = (r_state != S_IDLE);
    if (w_abort) begin
      bus.rst_flag = 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          bus.load      = bus.en_din;
          bus.load_addr = r_load_cnt;
        end
        S_START: begin
          bus.start_iter = 1'b1;
          bus.first_iter = (r_iter_cnt == '0);
        end
        S_FLUSH: bus.load_vout = 1'b1;
        S_OUT: begin
          bus.en_out    = 1'b1;
          bus.out_addr  = r_out_cnt;
          bus.shift_out = bus.out_ready;
        end
        S_DONE: begin
          bus.rst_flag   = 1'b0;
          bus.frame_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counters hold at their terminal value; the FSM leaves the state on that same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load_cnt  <= '0;
      r_out_cnt   <= '0;
      r_iter_cnt  <= '0;
      r_decode_ok <= 1'b0;
      r_limit     <= LP_MAX_ITER;
    end else if (w_abort) begin
      r_decode_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ready) begin
            r_load_cnt  <= '0;
            r_iter_cnt  <= '0;
            r_decode_ok <= 1'b0;
            r_limit     <= w_cfg_limit;
          end
        end
        S_LOAD: begin
          if (bus.en_din && r_load_cnt != LP_LOAD_LAST) r_load_cnt <= r_load_cnt + AW_IN'(1);
        end
        S_ITER: begin
          if (bus.iter_done) begin
            r_iter_cnt <= w_iter_inc;
            if (bus.syndrome_ok)            r_decode_ok <= 1'b1;
            else if (w_iter_inc == r_limit) r_decode_ok <= 1'b0;
          end
        end
        S_FLUSH: r_out_cnt <= '0;
        S_OUT: begin
          if (bus.out_ready && r_out_cnt != LP_OUT_LAST) r_out_cnt <= r_out_cnt + AW_OUT'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.decode_ok  = r_decode_ok;
  assign bus.iter_count = r_iter_cnt;
endmodule

// File: tb/tb_ldpc_decode_ctrl_p.sv
// Directed bench for ldpc_decode_ctrl_p: a table of whole-frame scenarios plus abort and reset sequences.
module tb_ldpc_decode_ctrl_p;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  ldpc_decode_ctrl_p_if #(.ITER_W(4), .AW_IN(5), .AW_OUT(4)) bus ();

  ldpc_decode_ctrl_p #(
    .LOAD_WORDS(24), .OUT_WORDS(12), .MAX_ITER(15),
    .ITER_W(4), .AW_IN(5), .AW_OUT(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cfg;
    int         syn_at;
    int         gap;
    bit         otog;
    bit         abort_out;
    int         exp_iter;
    int         exp_ok;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_inputs();
    bus.ready = 1'b0; bus.en_din = 1'b0; bus.iter_done = 1'b0;
    bus.syndrome_ok = 1'b0; bus.out_ready = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int cyc = 0, n_load = 0, n_start = 0, n_vout = 0, n_shift = 0, n_done = 0;
    int n_eno = 0, n_rf = 0, due = -1;
    int last_load = -10, last_idone = -10, vout_cyc = -1, first_eno = -1, done_cyc = -1;
    bit fin = 0, aborted = 0;
    @(negedge clk);
    bus.max_iter_cfg = v.cfg;
    bus.ready = 1'b1;
    #1 check("idle_busy", bus.busy, 0);
    @(negedge clk);
    bus.ready = 1'b0;
    while (!fin && cyc < 3000) begin
      bus.en_din      = (v.gap == 0) || (cyc % (v.gap + 1) == 0);
      bus.out_ready   = v.otog ? (cyc % 2 == 0) : 1'b1;
      bus.iter_done   = (cyc == due);
      bus.syndrome_ok = bus.iter_done ? (n_start == v.syn_at) : (cyc % 2 == 1);
      bus.abort       = v.abort_out && (vout_cyc >= 0) && (n_shift == 5);
      #1;
      if (bus.iter_done) last_idone = cyc;
      if (bus.abort) begin
        check("abort_out_en_out", bus.en_out, 0);
        check("abort_out_shift", bus.shift_out, 0);
        check("abort_out_rst_flag", bus.rst_flag, 0);
        check("abort_out_frame_done", bus.frame_done, 0);
        aborted = 1;
        fin = 1;
      end else begin
        if (bus.load) begin
          check("load_addr", bus.load_addr, n_load);
          n_load++;
          last_load = cyc;
        end
        if (bus.start_iter) begin
          check("first_iter", bus.first_iter, (n_start == 0));
          if (n_start == 0) check("lat_load_start", cyc, last_load + 1);
          else              check("lat_idone_start", cyc, last_idone + 1);
          n_start++;
          due = cyc + 3;
        end
        if (bus.load_vout) begin
          n_vout++;
          vout_cyc = cyc;
          check("lat_idone_vout", cyc, last_idone + 1);
        end
        if (bus.en_out) begin
          if (first_eno < 0) begin
            first_eno = cyc;
            check("lat_vout_enout", cyc, vout_cyc + 1);
          end
          n_eno++;
        end
        if (bus.shift_out) begin
          check("out_addr", bus.out_addr, n_shift);
          n_shift++;
        end
        if (!bus.rst_flag) n_rf++;
        if (bus.frame_done) begin
          n_done++;
          check("done_rst_flag", bus.rst_flag, 0);
          done_cyc = cyc;
          fin = 1;
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("frame_timeout", 0, 1);
    @(negedge clk);
    clear_inputs();
    #1;
    check("busy_after_frame", bus.busy, 0);
    check("rst_flag_after_frame", bus.rst_flag, 1);
    if (aborted) begin
      check("abort_out_decode_ok", bus.decode_ok, 0);
      check("abort_out_words", n_shift, 5);
    end else begin
      check("load_total", n_load, 24);
      check("start_total", n_start, v.exp_iter);
      check("vout_total", n_vout, 1);
      check("shift_total", n_shift, 12);
      check("done_total", n_done, 1);
      check("rst_flag_low_cycles", n_rf, 1);
      check("en_out_held", n_eno, done_cyc - vout_cyc - 1);
      check("iter_count", bus.iter_count, v.exp_iter);
      check("decode_ok", bus.decode_ok, v.exp_ok);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    //        cfg  syn gap otog abort iters ok
    vecs[0] = '{4'd0, 3, 0, 1'b0, 1'b0, 3,  1};
    vecs[1] = '{4'd4, 0, 0, 1'b0, 1'b0, 4,  0};
    vecs[2] = '{4'd0, 0, 0, 1'b0, 1'b0, 15, 0};
    vecs[3] = '{4'd2, 2, 0, 1'b0, 1'b0, 2,  1};
    vecs[4] = '{4'd5, 1, 2, 1'b1, 1'b0, 1,  1};
    vecs[5] = '{4'd1, 0, 0, 1'b0, 1'b0, 1,  0};
    vecs[6] = '{4'd0, 1, 0, 1'b0, 1'b1, 0,  0};
    vecs[7] = '{4'd3, 0, 1, 1'b1, 1'b0, 3,  0};

    rst_n = 1'b0;
    bus.max_iter_cfg = '0;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_rst_flag", bus.rst_flag, 1);
    check("reset_load", bus.load, 0);
    check("reset_iter_count", bus.iter_count, 0);
    check("reset_decode_ok", bus.decode_ok, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // abort while idle has no effect
    @(negedge clk);
    bus.abort = 1'b1;
    #1 check("idle_abort_rst_flag", bus.rst_flag, 1);
    @(negedge clk);
    bus.abort = 1'b0;
    #1 check("idle_abort_busy", bus.busy, 0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // abort on the 10th load cycle
    @(negedge clk);
    bus.max_iter_cfg = 4'd0;
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.en_din = 1'b1;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    #1;
    check("abort_load_addr_before", bus.busy, 1);
    check("abort_load_load", bus.load, 0);
    check("abort_load_rst_flag", bus.rst_flag, 0);
    check("abort_load_frame_done", bus.frame_done, 0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("abort_load_busy", bus.busy, 0);
    check("abort_load_rst_flag_after", bus.rst_flag, 1);
    check("abort_load_decode_ok", bus.decode_ok, 0);
    run_frame(vecs[0]);

    // asynchronous reset while iterating
    @(negedge clk);
    bus.max_iter_cfg = 4'd0;
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.en_din = 1'b1;
    repeat (24) @(negedge clk);
    bus.en_din = 1'b0;
    #1 check("rst_seq_start", bus.start_iter, 1);
    @(negedge clk);
    bus.iter_done = 1'b1;
    @(negedge clk);
    bus.iter_done = 1'b0;
    #1;
    check("rst_seq_iter_count", bus.iter_count, 1);
    check("rst_seq_restart", bus.start_iter, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_iter_count", bus.iter_count, 0);
    check("async_rst_rst_flag", bus.rst_flag, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_iter_count", bus.iter_count, 0);
    check("post_rst_rst_flag", bus.rst_flag, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ldpc_decode_ctrl_p.md
Name: ldpc_decode_ctrl_p

Overview:
Parametrised frame controller for the QC-LDPC NMS decoder datapath; next generation of the fixed decode sequencer. Counts input words itself instead of relying on ack, and drives an explicit per-iteration loop with early termination on syndrome pass or a runtime iteration limit. Counts output words under downstream backpressure instead of using f_out, and supports abort. Sits between the input buffer, the NMS core and the output shifter.

Parameters:
LOAD_WORDS, 24, input words per frame (>=2)
OUT_WORDS, 12, output words per frame (>=2)
MAX_ITER, 15, hard iteration ceiling (1..2^ITER_W-1)
ITER_W, 4, width of iteration counter/config
AW_IN, 5, load_addr width (2^AW_IN >= LOAD_WORDS)
AW_OUT, 4, out_addr width (2^AW_OUT >= OUT_WORDS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ready  in  1  frame available upstream (level, sampled in IDLE only)
en_din  in  1  input word valid this cycle
max_iter_cfg  in  ITER_W  runtime iteration limit; 0 or >MAX_ITER means MAX_ITER
iter_done  in  1  NMS core one-cycle pulse: iteration complete
syndrome_ok  in  1  all parity checks pass; qualified by iter_done
out_ready  in  1  downstream accepts output word
abort  in  1  synchronous frame abort
load  out  1  write input word at load_addr
load_addr  out  AW_IN  input word index
start_iter  out  1  one-cycle pulse: start one NMS iteration
first_iter  out  1  qualifies start_iter: first iteration of frame (core initialises from channel LLRs)
load_vout  out  1  one-cycle pulse: capture hard decisions into output shifter
en_out  out  1  output word valid
shift_out  out  1  output word transferred (en_out & out_ready)
out_addr  out  AW_OUT  output word index
rst_flag  out  1  active-low one-cycle flag clear, default 1
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on normal completion
decode_ok  out  1  registered: frame converged (syndrome pass)
iter_count  out  ITER_W  registered: iterations executed for current/last frame

Behaviour:
- Asynchronous rst_n low: state=IDLE, load_cnt=0, out_cnt=0, iter_count=0, decode_ok=0, limit reg=MAX_ITER. Combinational outputs are 0 except rst_flag=1. Illegal state encodings go to IDLE.
- States: IDLE, LOAD, START, ITER, FLUSH, OUT, DONE.
- IDLE: ready=1 -> LOAD; same edge clears load_cnt, iter_count, decode_ok; latches limit = (max_iter_cfg==0 || max_iter_cfg>MAX_ITER) ? MAX_ITER : max_iter_cfg.
- LOAD: load=en_din, load_addr=load_cnt. On en_din, load_cnt++. en_din=1 with load_cnt==LOAD_WORDS-1 -> START. en_din=0 stalls with no limit.
- START: start_iter=1 for exactly one cycle; first_iter=(iter_count==0). Next state ITER.
- ITER: wait for iter_done. On iter_done, iter_count <= iter_count+1, then:
  - if syndrome_ok: decode_ok<=1, go to FLUSH (syndrome_ok wins over the limit when both apply on the same pulse);
  - else if iter_count+1==limit: decode_ok<=0, go to FLUSH;
  - else go to START.
- FLUSH: load_vout=1 for one cycle; out_cnt<=0; next state OUT.
- OUT: en_out=1, out_addr=out_cnt, shift_out=out_ready. On out_ready, out_cnt++. out_ready with out_cnt==OUT_WORDS-1 -> DONE. out_ready=0 holds the word (backpressure, no limit).
- DONE: rst_flag=0 and frame_done=1 for one cycle; next state IDLE. decode_ok and iter_count hold until the next IDLE->LOAD.
- abort=1 in any non-IDLE state: next state IDLE; rst_flag=0 in that cycle; all other pulse outputs forced 0; no frame_done; decode_ok cleared. abort in IDLE is ignored; abort has priority over every other input.
- Ignored inputs: ready outside IDLE; en_din outside LOAD; iter_done outside ITER; syndrome_ok without iter_done; out_ready outside OUT.
- Latency:
  - last input word to first start_iter: 1 cycle;
  - iter_done to next start_iter: 1 cycle;
  - final iter_done to load_vout: 1 cycle;
  - load_vout to first en_out: 1 cycle.
- Counters never wrap: load_cnt and out_cnt stop at their terminal states; iter_count <= limit <= MAX_ITER.

Test Plan:
- Nominal: ready, 24 consecutive en_din, iter_done with syndrome_ok on 3rd pulse, out_ready held 1 -> load_addr 0..23; 3 start_iter pulses, first_iter only on the first; decode_ok=1, iter_count=3; 12 shift_out with out_addr 0..11; frame_done and rst_flag=0 in the same single cycle.
- Limit: max_iter_cfg=4, syndrome_ok never set -> exactly 4 start_iter; decode_ok=0, iter_count=4, then normal output phase. Repeat with max_iter_cfg=0 -> 15 iterations.
- Simultaneous: syndrome_ok on the iteration that reaches limit=2 -> decode_ok=1, iter_count=2.
- Stalls: en_din gapped (1 on/2 off), out_ready toggling -> load_addr and out_addr advance only on accepted cycles; en_out stays high through stalls; totals 24/12.
- Abort: abort on the 10th load cycle, and separately mid-OUT at out_addr=5 -> IDLE next cycle, rst_flag=0 one cycle, no frame_done, busy=0; next frame runs cleanly from load_addr 0.
- Reset: rst_n low during ITER -> outputs reset immediately (asynchronously); after release, state is IDLE, iter_count=0, rst_flag=1.
